button_debouncer: RTL and testbench
===================================

# button_debouncer

Front-end conditioning stage for the fan's push buttons. It synchronizes a raw, bouncing button pin to `clk` and filters it into a clean debounced level. It emits one-cycle press and release pulses and an optional one-cycle long-press pulse. Its outputs feed the fan mode, speed and timer control logic directly, and can also drive the downstream edge-detector stage.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000 — consecutive stable cycles required to accept a level change (1 ms at 100 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 100000000 — cycles a debounced press must be held before `long_press` fires (1 s at 100 MHz); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_p`  in  1  reset, synchronous, active-high.
- `btn`  in  1  raw button pin, asynchronous, active-high (1 = pressed).
- `btn_level`  out  1  debounced button level.
- `btn_pedge`  out  1  one-cycle pulse on debounced press.
- `btn_nedge`  out  1  one-cycle pulse on debounced release.
- `long_press`  out  1  one-cycle pulse when the hold time reaches `LONG_CYCLES`.

## Operation
- Synchronizer: two flip-flops, `btn` → `s1` → `s2`. Only `s2` is used downstream.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES)`.
  - When `s2 == btn_level`, the counter clears to 0.
  - When `s2 != btn_level`, the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `s2` still differs, `btn_level` toggles and the counter clears.
  - Any single cycle of agreement restarts the count. Bounces never accumulate.
- FSM, 4 states:
  - IDLE (released, stable): `s2==1` → PRESS_WAIT.
  - PRESS_WAIT: `s2==0` → IDLE. Debounce count complete → PRESSED, and assert `btn_pedge`.
  - PRESSED: `s2==0` → RELEASE_WAIT.
  - RELEASE_WAIT: `s2==1` → PRESSED. Count complete → IDLE, and assert `btn_nedge`.
- `btn_level` is 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- Hold counter (LONG_PRESS_EN only): width `$clog2(LONG_CYCLES+1)`.
  - Clears on entry to PRESSED.
  - Increments every cycle while `btn_level==1`, including RELEASE_WAIT.
  - Saturates at `LONG_CYCLES`.
  - `long_press` pulses on the single cycle the counter reaches `LONG_CYCLES`. Fires once per press; no auto-repeat.
  - Clears when the FSM enters IDLE.
- `btn_pedge` and `btn_nedge` are never asserted in the same cycle.
- `long_press` never coincides with `btn_pedge`. It may coincide with a RELEASE_WAIT bounce but never with `btn_nedge` if the count reaches `LONG_CYCLES` earlier; exact ties go to `long_press` first, then `btn_nedge` next cycle at earliest.

## Timing
- Reset values: `s1`, `s2`, both counters = 0; FSM = IDLE; all outputs 0.
- Press latency: raw `btn` rise to `btn_level`/`btn_pedge` is 2 sync cycles + `DEBOUNCE_CYCLES` cycles of stable `s2`. Release is symmetric.
- `btn_pedge` and `btn_nedge` are registered and high for exactly 1 cycle, aligned with the `btn_level` change.
- `long_press` asserts `LONG_CYCLES` cycles after the `btn_pedge` cycle.
- Reset mid-operation: all state clears on the next edge. If the button is still held after reset, it is re-debounced from scratch and a fresh `btn_pedge` is produced; no `btn_nedge` is generated for the aborted press.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no output activity.

## Configuration
- Macro: `BUTTON_DEBOUNCER_LONG_PRESS_EN`.
- Defined: the hold counter and `long_press` logic are compiled in as described above.
- Undefined: the hold counter is removed and `long_press` is tied to constant 0. The `LONG_CYCLES` parameter remains declared but unused. Debounce and edge behaviour are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `LONG_CYCLES=20`.
- Reset: assert `reset_p` with `btn=1` for 3 cycles, then release → all outputs 0 during reset; `btn_pedge` exactly 6 cycles after release.
- Clean press/release: `btn` 0→1, held 10 cycles, then 1→0 → `btn_pedge` 6 cycles after the rise; `btn_nedge` 6 cycles after the fall; `btn_level` high in between.
- Bounce: `btn` toggles 1,0,1,0 with 2-cycle pulses, then holds 1 → a single `btn_pedge`, 6 cycles after the final rise; no `btn_nedge`.
- Short glitch: one 3-cycle `btn` pulse → no activity on any output.
- Long press (macro on): hold 30 cycles → `long_press` pulses once, 20 cycles after `btn_pedge`; no repeat. With the macro off, `long_press` stays 0.
- Reset while held: `reset_p` pulsed 1 cycle at hold cycle 10 → outputs clear; fresh `btn_pedge` 6 cycles later; `long_press` timing restarts from the new `btn_pedge`.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer
//   Synchronizes a raw, bouncing push-button pin to clk and filters it into a
//   clean debounced level with one-cycle press/release pulses and an optional
//   one-cycle long-press pulse.
//
//   Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN
//     defined   - hold counter and long_press pulse are built in
//     undefined - long_press is tied to 0; LONG_CYCLES is accepted but unused
//
//   Parameters:
//     DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a change (>= 2)
//     LONG_CYCLES     - hold time after btn_pedge before long_press fires (>= 2)
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset_p    in   synchronous active-high reset
//     btn        in   raw asynchronous button pin, 1 = pressed
//     btn_level  out  debounced level
//     btn_pedge  out  one-cycle pulse on debounced press
//     btn_nedge  out  one-cycle pulse on debounced release
//     long_press out  one-cycle pulse when the hold time reaches LONG_CYCLES
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic btn,
    output logic btn_level,
    output logic btn_pedge,
    output logic btn_nedge,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;
    logic             stall;
    logic             take;
    logic             pedge_next;
    logic             nedge_next;

    assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);
    assign differ    = (s2 != btn_level);
    assign done      = differ && (cnt == CNT_LAST);
    // A completed release is held back one cycle when long_press fires on the
    // same edge, so the two pulses never coincide.
    assign take      = done && !stall;

    // Two-flop synchronizer
    always_ff @(posedge clk) begin
        if (reset_p) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce counter; any cycle of agreement restarts the count. While a
    // release is held back the counter parks at its last value.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt <= '0;
        end else if (!differ || take) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= IDLE;
            btn_pedge <= 1'b0;
            btn_nedge <= 1'b0;
        end else begin
            state     <= state_next;
            btn_pedge <= pedge_next;
            btn_nedge <= nedge_next;
        end
    end

    always_comb begin
        state_next = state;
        pedge_next = 1'b0;
        nedge_next = 1'b0;
        case (state)
            IDLE: begin
                if (s2) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_next = IDLE;
                end else if (take) begin
                    state_next = PRESSED;
                    pedge_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_next = PRESSED;
                end else if (take) begin
                    state_next = IDLE;
                    nedge_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold;
    logic              long_hit;
    logic              long_q;

    // Saturating at HOLD_MAX means HOLD_LAST is passed only once per press,
    // which gives the single, non-repeating pulse.
    assign long_hit   = btn_level && (hold == HOLD_LAST);
    assign stall      = long_hit;
    assign long_press = long_q;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            hold   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= long_hit;
            // Cleared on a fresh press and on return to IDLE only; a release
            // bounce back into PRESSED keeps the accumulated hold time.
            if (pedge_next || (state_next == IDLE)) begin
                hold <= '0;
            end else if (btn_level && (hold != HOLD_MAX)) begin
                hold <= hold + HOLD_W'(1);
            end
        end
    end
`else
    logic long_cycles_unused;

    assign long_cycles_unused = (LONG_CYCLES != 0);
    assign stall              = 1'b0;
    assign long_press         = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20. Inputs change 1 time unit after a rising edge; outputs are
// observed at the same point, so "cycle i" is the i-th rising edge after the
// stimulus change. Expected long_press behaviour follows
// BUTTON_DEBOUNCER_LONG_PRESS_EN.
module tb_button_debouncer;

    logic clk;
    logic reset_p;
    logic btn;
    logic btn_level;
    logic btn_pedge;
    logic btn_nedge;
    logic long_press;

    int total;
    int bad;

    // Observation results from the most recent observe() call
    int pe_cnt, pe_at, ne_cnt, ne_at, lp_cnt, lp_at, lvl_cnt, any_cnt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .btn       (btn),
        .btn_level (btn_level),
        .btn_pedge (btn_pedge),
        .btn_nedge (btn_nedge),
        .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs n cycles and records pulse counts and first-occurrence cycles.
    task automatic observe(input int n);
        pe_cnt = 0; pe_at = -1; ne_cnt = 0; ne_at = -1;
        lp_cnt = 0; lp_at = -1; lvl_cnt = 0; any_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (btn_pedge === 1'b1) begin
                pe_cnt++;
                if (pe_at < 0) pe_at = i;
            end
            if (btn_nedge === 1'b1) begin
                ne_cnt++;
                if (ne_at < 0) ne_at = i;
            end
            if (long_press === 1'b1) begin
                lp_cnt++;
                if (lp_at < 0) lp_at = i;
            end
            if (btn_level === 1'b1) lvl_cnt++;
            if ({btn_level, btn_pedge, btn_nedge, long_press} !== 4'b0000) any_cnt++;
        end
    endtask

    task automatic settle();
        btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn     = 1'b1;
        reset_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({btn_level, btn_pedge, btn_nedge, long_press} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0000", i,
                         {btn_level, btn_pedge, btn_nedge, long_press});
            end
        end
        reset_p = 1'b0;
        observe(8);
        total++;
        if (pe_at !== 6) begin
            bad++;
            $display("FAIL reset_pedge_at: got %0d want 6", pe_at);
        end
        total++;
        if (pe_cnt !== 1) begin
            bad++;
            $display("FAIL reset_pedge_cnt: got %0d want 1", pe_cnt);
        end
        btn = 1'b0;
        observe(10);
        total++;
        if (ne_at !== 6) begin
            bad++;
            $display("FAIL reset_release_nedge_at: got %0d want 6", ne_at);
        end
        settle();
    endtask

    task automatic test_clean();
        btn = 1'b1;
        observe(10);
        total++;
        if (pe_at !== 6) begin
            bad++;
            $display("FAIL clean_pedge_at: got %0d want 6", pe_at);
        end
        total++;
        if (pe_cnt !== 1 || ne_cnt !== 0) begin
            bad++;
            $display("FAIL clean_press_pulses: got pe=%0d ne=%0d want pe=1 ne=0", pe_cnt, ne_cnt);
        end
        total++;
        if (lvl_cnt !== 5) begin
            bad++;
            $display("FAIL clean_level_high_press: got %0d want 5", lvl_cnt);
        end
        btn = 1'b0;
        observe(10);
        total++;
        if (ne_at !== 6) begin
            bad++;
            $display("FAIL clean_nedge_at: got %0d want 6", ne_at);
        end
        total++;
        if (ne_cnt !== 1 || pe_cnt !== 0) begin
            bad++;
            $display("FAIL clean_release_pulses: got pe=%0d ne=%0d want pe=0 ne=1", pe_cnt, ne_cnt);
        end
        total++;
        if (lvl_cnt !== 5) begin
            bad++;
            $display("FAIL clean_level_high_release: got %0d want 5", lvl_cnt);
        end
        settle();
    endtask

    task automatic test_bounce();
        int act;
        act = 0;
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0) ? 1'b1 : 1'b0;
            observe(2);
            act += any_cnt;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL bounce_quiet: got %0d active cycles want 0", act);
        end
        btn = 1'b1;
        observe(10);
        total++;
        if (pe_at !== 6) begin
            bad++;
            $display("FAIL bounce_pedge_at: got %0d want 6", pe_at);
        end
        total++;
        if (pe_cnt !== 1 || ne_cnt !== 0) begin
            bad++;
            $display("FAIL bounce_pulses: got pe=%0d ne=%0d want pe=1 ne=0", pe_cnt, ne_cnt);
        end
        settle();
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        observe(3);
        act_check: begin
            int first;
            first = any_cnt;
            btn = 1'b0;
            observe(12);
            total++;
            if (first + any_cnt !== 0) begin
                bad++;
                $display("FAIL glitch_quiet: got %0d active cycles want 0", first + any_cnt);
            end
        end
    endtask

    task automatic test_long_press();
        btn = 1'b1;
        observe(30);
        total++;
        if (pe_at !== 6) begin
            bad++;
            $display("FAIL long_pedge_at: got %0d want 6", pe_at);
        end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        total++;
        if (lp_at !== 26) begin
            bad++;
            $display("FAIL long_at: got %0d want 26", lp_at);
        end
        total++;
        if (lp_cnt !== 1) begin
            bad++;
            $display("FAIL long_cnt: got %0d want 1", lp_cnt);
        end
`else
        total++;
        if (lp_cnt !== 0) begin
            bad++;
            $display("FAIL long_disabled: got %0d pulses want 0", lp_cnt);
        end
`endif
        btn = 1'b0;
        observe(10);
        total++;
        if (lp_cnt !== 0) begin
            bad++;
            $display("FAIL long_no_repeat: got %0d want 0", lp_cnt);
        end
        total++;
        if (ne_at !== 6) begin
            bad++;
            $display("FAIL long_nedge_at: got %0d want 6", ne_at);
        end
        settle();
    endtask

    task automatic test_reset_held();
        btn = 1'b1;
        observe(10);
        total++;
        if (pe_at !== 6) begin
            bad++;
            $display("FAIL held_first_pedge_at: got %0d want 6", pe_at);
        end
        reset_p = 1'b1;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        total++;
        if ({btn_level, btn_pedge, btn_nedge, long_press} !== 4'b0000) begin
            bad++;
            $display("FAIL held_reset_clear: got %b want 0000",
                     {btn_level, btn_pedge, btn_nedge, long_press});
        end
        observe(30);
        total++;
        if (pe_at !== 6 || pe_cnt !== 1) begin
            bad++;
            $display("FAIL held_fresh_pedge: got at=%0d cnt=%0d want at=6 cnt=1", pe_at, pe_cnt);
        end
        total++;
        if (ne_cnt !== 0) begin
            bad++;
            $display("FAIL held_no_nedge: got %0d want 0", ne_cnt);
        end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        total++;
        if (lp_at !== 26 || lp_cnt !== 1) begin
            bad++;
            $display("FAIL held_long: got at=%0d cnt=%0d want at=26 cnt=1", lp_at, lp_cnt);
        end
`else
        total++;
        if (lp_cnt !== 0) begin
            bad++;
            $display("FAIL held_long_disabled: got %0d want 0", lp_cnt);
        end
`endif
        settle();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        btn     = 1'b0;
        reset_p = 1'b1;
        test_reset();
        test_clean();
        test_bounce();
        test_glitch();
        test_long_press();
        test_reset_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
